// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - byte stream and status signals between the SPI slave and the register bridge
interface spi_reg_bridge_if;
   logic       i_cs_active;
   logic       i_rx_valid;
   logic [7:0] i_rx_data;
   logic [7:0] o_tx_data;
   logic [7:0] o_ctrl;
   logic       o_led;
   logic       o_busy;

   modport master (
      output i_cs_active, i_rx_valid, i_rx_data,
      input  o_tx_data, o_ctrl, o_led, o_busy
   );

   modport slave (
      input  i_cs_active, i_rx_valid, i_rx_data,
      output o_tx_data, o_ctrl, o_led, o_busy
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte command decoder with 16x8 register bank
// Define SPI_REG_PWM_EN to drive the LED through a DUTY-controlled PWM.
module spi_reg_bridge (
   input  logic             i_clk,
   input  logic             i_rst,
   spi_reg_bridge_if.slave  bus
);
   localparam logic [7:0] DEVICE_ID = 8'hA5;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_ERR} state_t;

   state_t      state, state_nxt;
   logic        cs_q;
   logic        wr_q;
   logic [3:0]  addr_q;
   logic [7:0]  regs [16];
   logic        cmd_ok, cmd_bad, data_stb;
   logic [7:0]  rd_data;
   logic [7:0]  tx_data;

   // cs_q resets high so a frame already in progress at reset is not re-entered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
         cs_q  <= 1'b1;
      end else begin
         state <= state_nxt;
         cs_q  <= bus.i_cs_active;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ok    = 1'b0;
      cmd_bad   = 1'b0;
      data_stb  = 1'b0;
      if (!bus.i_cs_active) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (!cs_q) state_nxt = ST_CMD;
            ST_CMD: begin
               if (bus.i_rx_valid) begin
                  if (|bus.i_rx_data[6:4]) begin
                     state_nxt = ST_ERR;
                     cmd_bad   = 1'b1;
                  end else begin
                     state_nxt = ST_DATA;
                     cmd_ok    = 1'b1;
                  end
               end
            end
            ST_DATA: data_stb = bus.i_rx_valid;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Entry 0 is never written; reads of address 0 return DEVICE_ID instead
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q   <= 1'b0;
         addr_q <= 4'd0;
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      end else begin
         if (cmd_ok) begin
            wr_q   <= bus.i_rx_data[7];
            addr_q <= bus.i_rx_data[3:0];
         end
         if (cmd_bad && regs[3] != 8'hFF) regs[3] <= regs[3] + 8'd1;
         if (data_stb) begin
            addr_q <= addr_q + 4'd1;
            if (wr_q && addr_q != 4'd0)
               regs[addr_q] <= (addr_q == 4'd3) ? 8'h00 : bus.i_rx_data;
         end
      end
   end

   assign rd_data = (addr_q == 4'd0) ? DEVICE_ID : regs[addr_q];

   always_comb begin
      tx_data = DEVICE_ID;
      case (state)
         ST_DATA: tx_data = wr_q ? 8'h00 : rd_data;
         ST_ERR:  tx_data = 8'hFF;
         default: tx_data = DEVICE_ID;
      endcase
   end

   assign bus.o_tx_data = tx_data;
   assign bus.o_ctrl    = regs[1];
   assign bus.o_busy    = (state == ST_CMD) || (state == ST_DATA);

`ifdef SPI_REG_PWM_EN
   logic [7:0] pwm_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) pwm_cnt <= 8'h00;
      else       pwm_cnt <= pwm_cnt + 8'd1;
   end

   assign bus.o_led = regs[1][0] & (pwm_cnt < regs[2]);
`else
   assign bus.o_led = regs[1][0];
`endif
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - randomized frame-level checks of spi_reg_bridge against a register-map model
module tb_spi_reg_bridge;
   logic clk = 1'b0;
   logic rst;

   spi_reg_bridge_if bus ();

   spi_reg_bridge dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #10 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // frame-level reference model
   int m_mem [16];
   int m_err;
   bit m_frame, m_bad, m_w;
   int m_pos, m_addr;

   bit [7:0] fq [$];

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int m_rd(input int a);
      if (a == 0) return 8'hA5;
      if (a == 3) return m_err;
      return m_mem[a];
   endfunction

   function automatic int m_tx();
      if (!m_frame || m_pos == 0) return 8'hA5;
      if (m_bad) return 8'hFF;
      if (m_w) return 8'h00;
      return m_rd(m_addr);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      m_err = 0; m_frame = 0; m_bad = 0; m_w = 0; m_pos = 0; m_addr = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_tx"}, bus.o_tx_data, m_tx());
      chk({tag, "_busy"}, bus.o_busy, (m_frame && !m_bad) ? 1 : 0);
      chk({tag, "_ctrl"}, bus.o_ctrl, m_mem[1]);
`ifndef SPI_REG_PWM_EN
      chk({tag, "_led"}, bus.o_led, m_mem[1] & 1);
`else
      if ((m_mem[1] & 1) == 0) chk({tag, "_led"}, bus.o_led, 0);
`endif
   endtask

   task automatic send_byte(input bit [7:0] b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = b;
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'($urandom);
      if (m_frame) begin
         if (m_pos == 0) begin
            if ((b & 8'h70) != 0) begin
               m_bad = 1;
               if (m_err < 255) m_err++;
            end else begin
               m_w    = b[7];
               m_addr = b & 15;
            end
            m_pos = 1;
         end else if (!m_bad) begin
            if (m_w) begin
               if (m_addr == 3)      m_err = 0;
               else if (m_addr != 0) m_mem[m_addr] = b;
            end
            m_addr = (m_addr + 1) % 16;
         end
      end
      check_outputs("byte");
   endtask

   task automatic cs_up();
      @(negedge clk);
      bus.i_cs_active = 1'b1;
      @(negedge clk);
      m_frame = 1; m_pos = 0; m_bad = 0;
      check_outputs("csup");
   endtask

   task automatic cs_down();
      @(negedge clk);
      bus.i_cs_active = 1'b0;
      @(negedge clk);
      m_frame = 0;
      check_outputs("csdn");
   endtask

   task automatic run_frame();
      cs_up();
      foreach (fq[i]) send_byte(fq[i]);
      cs_down();
   endtask

   initial begin
      rst = 1'b1;
      bus.i_cs_active = 1'b0;
      bus.i_rx_valid  = 1'b0;
      bus.i_rx_data   = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_tx", bus.o_tx_data, 8'hA5);
      chk("rst_ctrl", bus.o_ctrl, 8'h00);
      chk("rst_led", bus.o_led, 0);
      chk("rst_busy", bus.o_busy, 0);
      rst = 1'b0;

      // read ID, write burst, read back
      fq = '{8'h00, 8'h00};
      run_frame();
      fq = '{8'h81, 8'h01, 8'h40};
      run_frame();
      chk("wr_ctrl", bus.o_ctrl, 8'h01);
      fq = '{8'h01, 8'h00, 8'h00, 8'h00};
      run_frame();

      // wrap through address 15 into read-only register 0
      fq = '{8'h8F, 8'h11, 8'h22};
      run_frame();
      fq = '{8'h0F, 8'h00, 8'h00};
      run_frame();
      chk("wrap_m15", m_rd(15), 8'h11);

      // bad commands and ERRCNT saturation / clear
      fq = '{8'h90, 8'h55};
      run_frame();
      chk("err_one", m_err, 1);
      for (int i = 0; i < 256; i++) begin
         fq = '{8'h90};
         run_frame();
      end
      fq = '{8'h03, 8'h00};
      cs_up();
      send_byte(8'h03);
      chk("errcnt_sat", bus.o_tx_data, 8'hFF);
      cs_down();
      fq = '{8'h83, 8'h07};
      run_frame();
      fq = '{8'h03, 8'h00};
      run_frame();
      chk("errcnt_clr", m_err, 0);

      // abort mid-command and byte coincident with CS fall
      fq = '{8'h82};
      run_frame();
      cs_up();
      send_byte(8'h82);
      @(negedge clk);
      bus.i_cs_active = 1'b0;
      bus.i_rx_valid  = 1'b1;
      bus.i_rx_data   = 8'h99;
      @(negedge clk);
      bus.i_rx_valid  = 1'b0;
      m_frame = 0;
      check_outputs("abort");
      cs_up();
      send_byte(8'h02);
      chk("duty_kept", bus.o_tx_data, 8'h40);
      cs_down();

      // reset in the middle of a write burst
      cs_up();
      send_byte(8'h81);
      send_byte(8'h05);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_tx", bus.o_tx_data, 8'hA5);
      chk("mrst_busy", bus.o_busy, 0);
      chk("mrst_ctrl", bus.o_ctrl, 8'h00);
      chk("mrst_led", bus.o_led, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h82);
      cs_down();
      cs_up();
      send_byte(8'h02);
      chk("mrst_duty", bus.o_tx_data, 8'h00);
      cs_down();

      // randomized frames
      for (int f = 0; f < 300; f++) begin
         int len;
         bit [7:0] cmd;
         len = $urandom_range(1, 6);
         if ($urandom_range(0, 7) == 0) cmd = 8'($urandom);
         else cmd = {1'($urandom), 3'b000, 4'($urandom)};
         fq = '{cmd};
         for (int k = 1; k < len; k++) fq.push_back(8'($urandom));
         run_frame();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
